// File: rtl/lane_ctrl_if.sv
// Signal bundle between the lane sequencer and its roadside peers:
// sensors, E-pass reader, barrier driver and report serializer.
interface lane_ctrl_if;
    logic       sensor1;
    logic       sensor2;
    logic       sensor3;
    logic [1:0] valid_Epass;
    logic       enable;
    logic       uart_busy;
    logic       meas_start;
    logic       barrier;
    logic       tx_start;
    logic [1:0] tx_code;
    logic [2:0] state;

    modport master (
        input  sensor1, sensor2, sensor3, valid_Epass, enable, uart_busy,
        output meas_start, barrier, tx_start, tx_code, state
    );

    modport slave (
        output sensor1, sensor2, sensor3, valid_Epass, enable, uart_busy,
        input  meas_start, barrier, tx_start, tx_code, state
    );
endinterface

// File: rtl/lane_ctrl.sv
// Per-lane toll sequencer: follows one vehicle past three sensors, gates the
// barrier on the E-pass verdict, applies ms timeouts and requests a report.
module lane_ctrl #(
    parameter int unsigned SYS_FREQ   = 50000000,
    parameter int unsigned TIMEOUT_MS = 3000,
    parameter int unsigned HOLD_MS    = 500,
    parameter int unsigned WIDTH_MS   = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    lane_ctrl_if.master bus
);
    localparam int unsigned P  = SYS_FREQ / 1000;
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [WIDTH_MS-1:0] TIMEOUT = WIDTH_MS'(TIMEOUT_MS);
    localparam logic [WIDTH_MS-1:0] HOLD    = WIDTH_MS'(HOLD_MS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        CHECK  = 3'd2,
        OPEN   = 3'd3,
        CLEAR  = 3'd4,
        REPORT = 3'd5,
        DRAIN  = 3'd6
    } state_t;

    state_t              st;
    logic [4:0]          meta;
    logic [4:0]          sync;
    logic                s1_q;
    logic                s3_q;
    logic [1:0]          ep_q;
    logic [PW-1:0]       pre;
    logic [WIDTH_MS-1:0] timer;
    logic                meas_start_q;
    logic                tx_start_q;
    logic                barrier_q;
    logic [1:0]          tx_code_q;

    logic ms_tick;
    logic s1_rise;
    logic s3_rise;
    logic ep_valid;
    logic [1:0] ep_code;

    // bit order: {epass[1:0], sensor3, sensor2, sensor1}
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
            s1_q <= 1'b0;
            s3_q <= 1'b0;
            ep_q <= '0;
        end else begin
            meta <= {bus.valid_Epass, bus.sensor3, bus.sensor2, bus.sensor1};
            sync <= meta;
            s1_q <= sync[0];
            s3_q <= sync[2];
            ep_q <= sync[4:3];
        end
    end

    assign s1_rise  = sync[0] & ~s1_q;
    assign s3_rise  = sync[2] & ~s3_q;
    assign ep_code  = sync[4:3];
    assign ep_valid = (ep_code == ep_q) && (ep_code != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     pre <= '0;
        else if (ms_tick) pre <= '0;
        else              pre <= pre + PW'(1);
    end

    assign ms_tick = (pre == PW'(P - 1));

    // Timer increments by default; any state change below overrides it with a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st           <= IDLE;
            timer        <= '0;
            meas_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            barrier_q    <= 1'b0;
            tx_code_q    <= 2'b00;
        end else begin
            meas_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            if (ms_tick) timer <= timer + WIDTH_MS'(1);
            unique case (st)
                IDLE: if (s1_rise && bus.enable) begin
                    st           <= ARMED;
                    timer        <= '0;
                    meas_start_q <= 1'b1;
                end
                ARMED: if (sync[1]) begin
                    st    <= CHECK;
                    timer <= '0;
                end else if (timer == TIMEOUT) begin
                    st        <= REPORT;
                    timer     <= '0;
                    tx_code_q <= 2'b10;
                end
                CHECK: if (ep_valid && ep_code == 2'b01) begin
                    st        <= OPEN;
                    timer     <= '0;
                    barrier_q <= 1'b1;
                end else if (ep_valid) begin
                    st        <= REPORT;
                    timer     <= '0;
                    tx_code_q <= 2'b01;
                end else if (timer == TIMEOUT) begin
                    st        <= REPORT;
                    timer     <= '0;
                    tx_code_q <= 2'b10;
                end
                OPEN: if (s3_rise) begin
                    st    <= CLEAR;
                    timer <= '0;
                end
                CLEAR: if (sync[2]) begin
                    timer <= '0;
                end else if (timer == HOLD) begin
                    st        <= REPORT;
                    timer     <= '0;
                    barrier_q <= 1'b0;
                    tx_code_q <= 2'b00;
                end
                REPORT: if (!bus.uart_busy) begin
                    st         <= DRAIN;
                    timer      <= '0;
                    tx_start_q <= 1'b1;
                end
                DRAIN: if (sync[2:0] == 3'b000) begin
                    st    <= IDLE;
                    timer <= '0;
                end
                default: begin
                    st        <= IDLE;
                    timer     <= '0;
                    barrier_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.meas_start = meas_start_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.barrier    = barrier_q;
    assign bus.tx_code    = tx_code_q;
    assign bus.state      = st;
endmodule

// File: tb/tb_lane_ctrl.sv
// Directed table-driven bench for lane_ctrl with P=4, TIMEOUT_MS=10, HOLD_MS=5.
module tb_lane_ctrl;
    logic clk;
    logic reset_n;
    lane_ctrl_if bus();

    lane_ctrl #(
        .SYS_FREQ  (4000),
        .TIMEOUT_MS(10),
        .HOLD_MS   (5),
        .WIDTH_MS  (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int meas_cnt = 0;
    int tx_cnt   = 0;
    int overlap  = 0;
    int wide     = 0;
    logic meas_d = 1'b0;
    logic tx_d   = 1'b0;

    always @(negedge clk) begin
        if (bus.meas_start) meas_cnt++;
        if (bus.tx_start) tx_cnt++;
        if (bus.meas_start && bus.tx_start) overlap++;
        if ((bus.meas_start && meas_d) || (bus.tx_start && tx_d)) wide++;
        meas_d = bus.meas_start;
        tx_d   = bus.tx_start;
    end

    typedef struct {
        logic       s1, s2, s3;
        logic [1:0] ep;
        logic       en, busy;
        int         lo, hi;
        int         st;
        int         bar;
        int         code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s1, input logic s2, input logic s3,
                                input logic [1:0] ep, input logic en, input logic busy,
                                input int lo, input int hi,
                                input int st, input int bar, input int code);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.s3 = s3; v.ep = ep; v.en = en; v.busy = busy;
        v.lo = lo; v.hi = hi; v.st = st; v.bar = bar; v.code = code;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic s1, input logic s2, input logic s3,
                         input logic [1:0] ep, input logic en, input logic busy);
        bus.sensor1     = s1;
        bus.sensor2     = s2;
        bus.sensor3     = s3;
        bus.valid_Epass = ep;
        bus.enable      = en;
        bus.uart_busy   = busy;
    endtask

    // lo==hi: wait exactly hi edges; otherwise poll for st, bounded by hi edges
    task automatic apply_row(input int idx, input vec_t v);
        int n;
        drive(v.s1, v.s2, v.s3, v.ep, v.en, v.busy);
        n = 0;
        if (v.lo == v.hi) begin
            step(v.hi);
            n = v.hi;
        end else begin
            do begin
                step(1);
                n++;
            end while (int'(bus.state) != v.st && n < v.hi);
            check_range($sformatf("row%0d_latency", idx), n, v.lo, v.hi);
        end
        check($sformatf("row%0d_state", idx), int'(bus.state), v.st);
        check($sformatf("row%0d_barrier", idx), int'(bus.barrier), v.bar);
        check($sformatf("row%0d_tx_code", idx), int'(bus.tx_code), v.code);
    endtask

    initial begin
        int n;
        int bad;

        // pass: s1, s2 20 cycles later, Epass 01, s3, then release
        vecs.push_back(mk(1,0,0,2'b00,1,0,  2, 2, 0,0,0));
        vecs.push_back(mk(1,0,0,2'b00,1,0,  1, 1, 1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,1,0, 17,17, 1,0,0));
        vecs.push_back(mk(1,1,0,2'b00,1,0,  3, 3, 2,0,0));
        vecs.push_back(mk(1,1,0,2'b00,1,0,  7, 7, 2,0,0));
        vecs.push_back(mk(1,1,0,2'b01,1,0,  2, 2, 2,0,0));
        vecs.push_back(mk(1,1,0,2'b01,1,0,  2, 2, 3,1,0));
        vecs.push_back(mk(1,1,1,2'b01,1,0,  3, 3, 4,1,0));
        vecs.push_back(mk(0,0,1,2'b01,1,0, 10,10, 4,1,0));
        vecs.push_back(mk(0,0,0,2'b00,1,0, 16,16, 4,1,0));
        vecs.push_back(mk(0,0,0,2'b00,1,0,  1, 8, 5,0,0));
        vecs.push_back(mk(0,0,0,2'b00,1,0,  1, 1, 6,0,0));
        vecs.push_back(mk(0,0,0,2'b00,1,0,  1, 1, 0,0,0));
        // timeout in ARMED
        vecs.push_back(mk(1,0,0,2'b00,1,0,  3, 3, 1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,1,0, 36,42, 5,0,2));
        vecs.push_back(mk(1,0,0,2'b00,1,0,  1, 1, 6,0,2));
        vecs.push_back(mk(1,0,0,2'b00,1,0,  4, 4, 6,0,2));
        vecs.push_back(mk(0,0,0,2'b00,1,0,  3, 3, 0,0,2));
        // reject
        vecs.push_back(mk(1,0,0,2'b00,1,0,  3, 3, 1,0,2));
        vecs.push_back(mk(1,1,0,2'b00,1,0,  3, 3, 2,0,2));
        vecs.push_back(mk(1,1,0,2'b10,1,0,  4, 4, 5,0,1));
        vecs.push_back(mk(1,1,0,2'b10,1,0,  1, 1, 6,0,1));
        vecs.push_back(mk(1,1,1,2'b00,1,0,  5, 5, 6,0,1));
        vecs.push_back(mk(0,0,1,2'b00,1,0,  3, 3, 6,0,1));
        vecs.push_back(mk(0,0,0,2'b00,1,0,  3, 3, 0,0,1));
        // s1 with lane disabled
        vecs.push_back(mk(1,0,0,2'b00,0,0,  6, 6, 0,0,1));
        vecs.push_back(mk(0,0,0,2'b00,0,0,  3, 3, 0,0,1));

        reset_n = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0);
        step(2);
        check("reset_state", int'(bus.state), 0);
        check("reset_barrier", int'(bus.barrier), 0);
        check("reset_meas_start", int'(bus.meas_start), 0);
        check("reset_tx_start", int'(bus.tx_start), 0);
        check("reset_tx_code", int'(bus.tx_code), 0);
        reset_n = 1'b1;
        step(2);

        for (int i = 0; i < vecs.size(); i++) apply_row(i, vecs[i]);

        check("table_meas_pulses", meas_cnt, 3);
        check("table_tx_pulses", tx_cnt, 3);

        // timeout in CHECK with a one-cycle 01 glitch, report held off by uart_busy
        drive(1, 1, 0, 2'b00, 1, 0);
        step(3);
        check("simul_armed", int'(bus.state), 1);
        step(1);
        check("simul_check", int'(bus.state), 2);
        bus.valid_Epass = 2'b01;
        step(1);
        bus.valid_Epass = 2'b00;
        bus.uart_busy   = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
            if (int'(bus.state) == 3) begin
                check("glitch_ignored", int'(bus.state), 2);
                n = 60;
            end
        end while (int'(bus.state) != 5 && n < 60);
        check_range("check_timeout_latency", n, 30, 45);
        check("check_timeout_state", int'(bus.state), 5);
        check("check_timeout_code", int'(bus.tx_code), 2);
        check("check_timeout_barrier", int'(bus.barrier), 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.tx_start || int'(bus.state) != 5) bad++;
        end
        check("busy_hold", bad, 0);
        bus.uart_busy = 1'b0;
        step(1);
        check("busy_release_tx_start", int'(bus.tx_start), 1);
        check("busy_release_state", int'(bus.state), 6);
        step(1);
        check("tx_start_width", int'(bus.tx_start), 0);
        drive(0, 0, 0, 2'b00, 1, 0);
        step(3);
        check("check_timeout_idle", int'(bus.state), 0);

        // reset while the barrier is open
        drive(1, 0, 0, 2'b00, 1, 0);
        step(3);
        drive(1, 1, 0, 2'b00, 1, 0);
        step(3);
        drive(1, 1, 0, 2'b01, 1, 0);
        step(4);
        check("pre_reset_state", int'(bus.state), 3);
        check("pre_reset_barrier", int'(bus.barrier), 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_barrier", int'(bus.barrier), 0);
        check("async_reset_state", int'(bus.state), 0);
        drive(0, 0, 0, 2'b00, 1, 0);
        step(2);
        reset_n = 1'b1;
        step(10);
        check("post_reset_state", int'(bus.state), 0);
        check("post_reset_barrier", int'(bus.barrier), 0);

        check("total_meas_pulses", meas_cnt, 5);
        check("total_tx_pulses", tx_cnt, 4);
        check("pulse_overlap", overlap, 0);
        check("pulse_width", wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
